// File: rtl/load_store_unit_pkg.sv
// Shared LSU types: RISC-V load/store funct3 encodings, FSM states and error codes.
package load_store_unit_pkg;

  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned ERR_W    = 2;

  localparam logic [FUNCT3_W-1:0] FUNCT3_LB  = 3'd0;
  localparam logic [FUNCT3_W-1:0] FUNCT3_LH  = 3'd1;
  localparam logic [FUNCT3_W-1:0] FUNCT3_LW  = 3'd2;
  localparam logic [FUNCT3_W-1:0] FUNCT3_LBU = 3'd4;
  localparam logic [FUNCT3_W-1:0] FUNCT3_LHU = 3'd5;
  localparam logic [FUNCT3_W-1:0] FUNCT3_SB  = 3'd0;
  localparam logic [FUNCT3_W-1:0] FUNCT3_SH  = 3'd1;
  localparam logic [FUNCT3_W-1:0] FUNCT3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_NULL     = 2'b10,
    ERR_FUNCT3   = 2'b11
  } lsu_err_e;

  // Stores only encode byte/half/word; loads additionally have the unsigned variants.
  function automatic logic funct3_legal(input logic [FUNCT3_W-1:0] funct3, input logic is_store);
    logic ok;
    if (is_store) begin
      ok = (funct3 == FUNCT3_SB) || (funct3 == FUNCT3_SH) || (funct3 == FUNCT3_SW);
    end else begin
      ok = (funct3 == FUNCT3_LB) || (funct3 == FUNCT3_LH) || (funct3 == FUNCT3_LW) ||
           (funct3 == FUNCT3_LBU) || (funct3 == FUNCT3_LHU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align_check.sv
// Combinational legality check of an access: funct3 first, then null address, then alignment.
module lsu_align_check
  import load_store_unit_pkg::*;
#(
  parameter int unsigned AWIDTH = 32
) (
  input  logic [AWIDTH-1:0]   addr_i,
  input  logic [FUNCT3_W-1:0] funct3_i,
  input  logic                is_store_i,
  output logic [ERR_W-1:0]    err_o
);

  logic w_misaligned;

  // funct3[1:0] encodes access size for every legal load/store (01 = half, 10 = word).
  assign w_misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

  always_comb begin
    err_o = ERR_W'(ERR_NONE);
    if (!funct3_legal(funct3_i, is_store_i)) begin
      err_o = ERR_W'(ERR_FUNCT3);
    end else if (addr_i == '0) begin
      err_o = ERR_W'(ERR_NULL);
    end else if (w_misaligned) begin
      err_o = ERR_W'(ERR_MISALIGN);
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage front end: accepts one request, performs a single-cycle memory access,
// and holds a registered response until writeback takes it.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [AWIDTH-1:0]   req_addr_i,
  input  logic [DWIDTH-1:0]   req_wdata_i,
  input  logic [FUNCT3_W-1:0] req_funct3_i,
  input  logic                req_is_store_i,
  input  logic [4:0]          req_rd_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [DWIDTH-1:0]   resp_rdata_o,
  output logic [4:0]          resp_rd_o,
  output logic                resp_is_store_o,
  output logic [ERR_W-1:0]    resp_err_o,
  output logic [AWIDTH-1:0]   mem_addr_o,
  output logic [DWIDTH-1:0]   mem_data_o,
  output logic [FUNCT3_W-1:0] mem_funct3_o,
  output logic                mem_read_en_o,
  output logic                mem_write_en_o,
  input  logic [DWIDTH-1:0]   mem_data_i
);

  lsu_state_e          r_state;
  logic [AWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_wdata;
  logic [DWIDTH-1:0]   r_rdata;
  logic [FUNCT3_W-1:0] r_funct3;
  logic                r_is_store;
  logic [4:0]          r_rd;
  logic [ERR_W-1:0]    r_err;

  logic                w_accept;
  logic                w_access;
  logic [ERR_W-1:0]    w_err;

  lsu_align_check #(
    .AWIDTH (AWIDTH)
  ) u_align_check (
    .addr_i     (req_addr_i),
    .funct3_i   (req_funct3_i),
    .is_store_i (req_is_store_i),
    .err_o      (w_err)
  );

  // Ready while a held response is being consumed lets a new request slip in back-to-back.
  assign req_ready_o = (r_state == IDLE) || ((r_state == RESP) && resp_ready_i);
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_access    = (r_state == ACCESS);

  // Gating with rst keeps a reset landing on ACCESS from committing the store.
  assign mem_read_en_o  = w_access && !r_is_store && rst;
  assign mem_write_en_o = w_access && r_is_store && rst;
  assign mem_addr_o     = r_addr;
  assign mem_data_o     = r_wdata;
  assign mem_funct3_o   = r_funct3;

  assign resp_valid_o    = (r_state == RESP);
  assign resp_rdata_o    = r_rdata;
  assign resp_rd_o       = r_rd;
  assign resp_is_store_o = r_is_store;
  assign resp_err_o      = r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_funct3   <= '0;
      r_is_store <= 1'b0;
      r_rd       <= '0;
      r_err      <= ERR_W'(ERR_NONE);
    end else if (w_accept) begin
      r_addr     <= req_addr_i;
      r_wdata    <= req_wdata_i;
      r_funct3   <= req_funct3_i;
      r_is_store <= req_is_store_i;
      r_rd       <= req_rd_i;
      r_err      <= w_err;
      r_rdata    <= '0;
      r_state    <= (w_err == ERR_W'(ERR_NONE)) ? ACCESS : RESP;
    end else begin
      case (r_state)
        ACCESS: begin
          r_rdata <= r_is_store ? '0 : mem_data_i;
          r_state <= RESP;
        end
        RESP: begin
          if (resp_ready_i) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a byte-array memory stub and a request-level reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [2:0]  req_funct3_i;
  logic        req_is_store_i;
  logic [4:0]  req_rd_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic [4:0]  resp_rd_o;
  logic        resp_is_store_o;
  logic [1:0]  resp_err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [2:0]  mem_funct3_o;
  logic        mem_read_en_o;
  logic        mem_write_en_o;
  logic [31:0] mem_data_i;

  always #5 clk = ~clk;

  load_store_unit #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_wdata_i     (req_wdata_i),
    .req_funct3_i    (req_funct3_i),
    .req_is_store_i  (req_is_store_i),
    .req_rd_i        (req_rd_i),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_rdata_o    (resp_rdata_o),
    .resp_rd_o       (resp_rd_o),
    .resp_is_store_o (resp_is_store_o),
    .resp_err_o      (resp_err_o),
    .mem_addr_o      (mem_addr_o),
    .mem_data_o      (mem_data_o),
    .mem_funct3_o    (mem_funct3_o),
    .mem_read_en_o   (mem_read_en_o),
    .mem_write_en_o  (mem_write_en_o),
    .mem_data_i      (mem_data_i)
  );

  typedef struct {
    int          acc;
    logic [1:0]  err;
    logic        st;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
  } exp_t;

  logic [7:0]  mem     [0:1023];
  logic [7:0]  ref_mem [0:1023];
  exp_t        q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  bit          last_acc;
  logic [31:0] last_rdata;
  logic [1:0]  last_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fetch(input bit use_ref, input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      w[8*i +: 8] = use_ref ? ref_mem[(a + 32'(i)) & 32'h3FF] : mem[(a + 32'(i)) & 32'h3FF];
    end
    return w;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      3'd0:    return {{24{raw[7]}}, raw[7:0]};
      3'd1:    return {{16{raw[15]}}, raw[15:0]};
      3'd2:    return raw;
      3'd4:    return {24'd0, raw[7:0]};
      3'd5:    return {16'd0, raw[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] model_err(input logic [31:0] a, input logic [2:0] f3, input logic st);
    bit legal;
    int sz;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 2'b11;
    if (a == 32'd0) return 2'b10;
    sz = 1 << f3[1:0];
    if ((a % 32'(sz)) != 32'd0) return 2'b01;
    return 2'b00;
  endfunction

  // Memory stub: combinational-style read refreshed each low phase, byte-lane write on the edge.
  always @(negedge clk) mem_data_i = extend(fetch(1'b0, mem_addr_o), mem_funct3_o);

  always @(posedge clk) begin
    if (mem_write_en_o) begin
      for (int i = 0; i < (1 << mem_funct3_o[1:0]); i++) begin
        mem[(mem_addr_o + 32'(i)) & 32'h3FF] = mem_data_o[8*i +: 8];
      end
    end
  end

  task automatic do_cycle();
    exp_t e;
    bit   vexp, enexp, acc, fire;
    e = '{default: '0};
    #1;
    if (q.size() == 0) begin
      vexp  = 1'b0;
      enexp = 1'b0;
    end else begin
      e     = q[0];
      enexp = (e.err == 2'b00) && (cyc == e.acc);
      vexp  = (e.err != 2'b00) || (cyc > e.acc);
    end
    check_eq("resp_valid", 32'(resp_valid_o), 32'(vexp));
    check_eq("req_ready", 32'(req_ready_o), 32'((q.size() == 0) || (vexp && resp_ready_i)));
    check_eq("read_en", 32'(mem_read_en_o), 32'(enexp && !e.st));
    check_eq("write_en", 32'(mem_write_en_o), 32'(enexp && e.st));
    if (enexp) begin
      check_eq("mem_addr", mem_addr_o, e.addr);
      check_eq("mem_data", mem_data_o, e.wdata);
      check_eq("mem_funct3", 32'(mem_funct3_o), 32'(e.f3));
    end
    if (vexp) begin
      check_eq("resp_rdata", resp_rdata_o, e.rdata);
      check_eq("resp_rd", 32'(resp_rd_o), 32'(e.rd));
      check_eq("resp_is_store", 32'(resp_is_store_o), 32'(e.st));
      check_eq("resp_err", 32'(resp_err_o), 32'(e.err));
    end
    acc  = req_valid_i && req_ready_o;
    fire = resp_valid_o && resp_ready_i;
    if (fire) begin
      last_rdata = resp_rdata_o;
      last_err   = resp_err_o;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (acc) begin
      e.acc   = cyc + 1;
      e.addr  = req_addr_i;
      e.wdata = req_wdata_i;
      e.f3    = req_funct3_i;
      e.st    = req_is_store_i;
      e.rd    = req_rd_i;
      e.err   = model_err(req_addr_i, req_funct3_i, req_is_store_i);
      e.rdata = 32'd0;
      if (e.err == 2'b00) begin
        if (e.st) begin
          for (int i = 0; i < (1 << e.f3[1:0]); i++) begin
            ref_mem[(e.addr + 32'(i)) & 32'h3FF] = e.wdata[8*i +: 8];
          end
        end else begin
          e.rdata = extend(fetch(1'b1, e.addr), e.f3);
        end
      end
      q.push_back(e);
    end
    last_acc = acc;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    while (q.size() > 0 && n < 10) begin
      do_cycle();
      n++;
    end
    if (q.size() > 0) begin
      check_eq("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                      input logic st, input logic [4:0] rd);
    int n;
    n = 0;
    req_addr_i     = a;
    req_wdata_i    = wd;
    req_funct3_i   = f3;
    req_is_store_i = st;
    req_rd_i       = rd;
    req_valid_i    = 1'b1;
    resp_ready_i   = 1'b1;
    do begin
      do_cycle();
      n++;
    end while (!last_acc && n < 10);
    check_eq("accept_timeout", 32'(last_acc), 32'd1);
    req_valid_i = 1'b0;
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    logic [7:0]  saved [0:3];
    logic [31:0] saved_w;
    rst            = 1'b0;
    req_valid_i    = 1'b0;
    req_addr_i     = '0;
    req_wdata_i    = '0;
    req_funct3_i   = '0;
    req_is_store_i = 1'b0;
    req_rd_i       = '0;
    resp_ready_i   = 1'b0;
    last_rdata     = '0;
    last_err       = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check_eq("rst_resp_err", 32'(resp_err_o), 32'd0);
    check_eq("rst_resp_rdata", resp_rdata_o, 32'd0);
    check_eq("rst_resp_rd", 32'(resp_rd_o), 32'd0);
    check_eq("rst_mem_addr", mem_addr_o, 32'd0);
    check_eq("rst_mem_en", 32'({mem_read_en_o, mem_write_en_o}), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);

    // Directed scenarios
    {mem[16], mem[17], mem[18], mem[19]} = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
    {ref_mem[16], ref_mem[17], ref_mem[18], ref_mem[19]} = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send(32'h01000010, 32'd0, 3'd2, 1'b0, 5'd7);
    check_eq("lw_deadbeef", last_rdata, 32'hDEADBEEF);
    send(32'h01000022, 32'h1234ABCD, 3'd1, 1'b1, 5'd3);
    send(32'h01000022, 32'd0, 3'd5, 1'b0, 5'd4);
    check_eq("lhu_abcd", last_rdata, 32'h0000ABCD);
    send(32'h01000002, 32'd0, 3'd2, 1'b0, 5'd5);
    check_eq("lw_misalign", 32'(last_err), 32'd1);
    send(32'h01000001, 32'h5555, 3'd1, 1'b1, 5'd6);
    check_eq("sh_misalign", 32'(last_err), 32'd1);
    send(32'h00000000, 32'd0, 3'd2, 1'b0, 5'd8);
    check_eq("null_addr", 32'(last_err), 32'd2);
    send(32'h00000000, 32'd0, 3'd3, 1'b0, 5'd9);
    check_eq("funct3_wins", 32'(last_err), 32'd3);
    send(32'h01000004, 32'd1, 3'd3, 1'b1, 5'd10);
    check_eq("store_funct3", 32'(last_err), 32'd3);

    // Writeback stall with a new request waiting, then same-cycle handoff
    send(32'h01000010, 32'd0, 3'd2, 1'b0, 5'd11);
    req_addr_i = 32'h01000010; req_funct3_i = 3'd2; req_is_store_i = 1'b0; req_rd_i = 5'd12;
    req_valid_i = 1'b1; resp_ready_i = 1'b1;
    do_cycle();
    req_addr_i = 32'h01000011; req_funct3_i = 3'd0; req_rd_i = 5'd13;
    resp_ready_i = 1'b0;
    repeat (7) do_cycle();
    resp_ready_i = 1'b1;
    do_cycle();
    check_eq("handoff_accept", 32'(last_acc), 32'd1);
    req_valid_i = 1'b0;
    drain();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if (!(req_valid_i && !last_acc)) begin
        req_valid_i    = ($urandom % 4) != 0;
        req_is_store_i = 1'($urandom);
        req_addr_i     = (($urandom % 16) == 0) ? 32'd0 : (32'h01000000 | ($urandom & 32'h3FF));
        req_wdata_i    = $urandom;
        req_rd_i       = 5'($urandom);
        if (($urandom % 4) == 0) begin
          req_funct3_i = 3'($urandom_range(0, 7));
        end else if (req_is_store_i) begin
          req_funct3_i = 3'($urandom_range(0, 2));
        end else begin
          case ($urandom % 5)
            0: req_funct3_i = 3'd0;
            1: req_funct3_i = 3'd1;
            2: req_funct3_i = 3'd2;
            3: req_funct3_i = 3'd4;
            default: req_funct3_i = 3'd5;
          endcase
        end
      end
      resp_ready_i = ($urandom % 10) < 7;
      do_cycle();
    end
    drain();

    // Reset landing on the ACCESS cycle of a store
    for (int i = 0; i < 4; i++) saved[i] = mem[64 + i];
    saved_w = {saved[3], saved[2], saved[1], saved[0]};
    req_addr_i = 32'h01000040; req_wdata_i = 32'hCAFEF00D; req_funct3_i = 3'd2;
    req_is_store_i = 1'b1; req_rd_i = 5'd14; req_valid_i = 1'b1; resp_ready_i = 1'b1;
    do_cycle();
    check_eq("rst_sw_accept", 32'(last_acc), 32'd1);
    req_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("rst_gates_write", 32'(mem_write_en_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_mem_kept", {mem[67], mem[66], mem[65], mem[64]}, saved_w);
    check_eq("rst_no_resp", 32'(resp_valid_o), 32'd0);
    check_eq("rst_idle_ready", 32'(req_ready_o), 32'd1);
    check_eq("rst_addr_zero", mem_addr_o, 32'd0);
    check_eq("rst_data_zero", mem_data_o, 32'd0);
    check_eq("rst_store_flag", 32'(resp_is_store_o), 32'd0);
    q.delete();
    for (int i = 0; i < 4; i++) ref_mem[64 + i] = saved[i];
    rst = 1'b1;
    @(negedge clk);
    send(32'h01000040, 32'd0, 3'd2, 1'b0, 5'd15);
    check_eq("rst_readback", last_rdata, saved_w);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
